alu_arbiter: RTL and testbench

- Shares one combinational alu instance between two requesters (port 0, port 1).
- Uses valid/ready handshakes and round-robin arbitration.
- Drives the shared ALU's operand and control inputs, then captures its result and carry into a one-entry response register.
- Returns each result to the requester that issued it, one cycle after the request is accepted.

---
 rtl/alu_arbiter.sv | 101 ++++++++++
 tb/tb_alu_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready
// requesters, with a one-entry registered response returned to the issuer.
module alu_arbiter #(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [1:0]   i_req_valid,
  output logic [1:0]   o_req_ready,
  input  logic [N-1:0] i_req0_a,
  input  logic [N-1:0] i_req0_b,
  input  logic [1:0]   i_req0_ctrl,
  input  logic [N-1:0] i_req1_a,
  input  logic [N-1:0] i_req1_b,
  input  logic [1:0]   i_req1_ctrl,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [1:0]   o_alu_ctrl,
  input  logic [N-1:0] i_alu_result,
  input  logic         i_alu_carry,
  output logic [1:0]   o_rsp_valid,
  input  logic [1:0]   i_rsp_ready,
  output logic [N-1:0] o_rsp_result,
  output logic         o_rsp_carry
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e      state_q;
  logic        rsp_owner_q;
  logic        rr_ptr_q;
  logic [1:0]  rsp_valid_q;
  logic [N-1:0] rsp_result_q;
  logic        rsp_carry_q;

  logic        consume;
  logic        can_issue;
  logic [1:0]  grant;

  // Only the owning port's ready frees the slot; the other bit is ignored.
  assign consume   = (state_q == FULL) && i_rsp_ready[rsp_owner_q];
  assign can_issue = !i_reset && ((state_q == EMPTY) || consume);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves grant unassigned (no latch).
    grant = 2'b00;
    if (can_issue) begin
      case (i_req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign o_req_ready = grant;

  // Operands go straight to the ALU; its result is captured at the grant edge.
  always_comb begin
    o_alu_a    = '0;
    o_alu_b    = '0;
    o_alu_ctrl = 2'b00;
    if (grant[0]) begin
      o_alu_a    = i_req0_a;
      o_alu_b    = i_req0_b;
      o_alu_ctrl = i_req0_ctrl;
    end else if (grant[1]) begin
      o_alu_a    = i_req1_a;
      o_alu_b    = i_req1_b;
      o_alu_ctrl = i_req1_ctrl;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset) begin
      state_q      <= EMPTY;
      rsp_owner_q  <= 1'b0;
      rr_ptr_q     <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else if (grant != 2'b00) begin
      state_q      <= FULL;
      rsp_owner_q  <= grant[1];
      rr_ptr_q     <= ~grant[1];
      rsp_valid_q  <= grant;
      rsp_result_q <= i_alu_result;
      rsp_carry_q  <= i_alu_carry;
    end else if (consume) begin
      state_q     <= EMPTY;
      rsp_valid_q <= 2'b00;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N=8) with a behavioural shared ALU and
// hand-computed expected grants, results and carries.
module tb_alu_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]   req0_ctrl, req1_ctrl;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic [1:0]   alu_ctrl;
  logic         alu_carry;
  logic [1:0]   rsp_valid, rsp_ready;
  logic [N-1:0] rsp_result;
  logic         rsp_carry;
  logic [N:0]   alu_sum;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Shared ALU: odd ctrl feeds ~b and carry-in 1 to the adder.
  assign alu_sum   = {1'b0, alu_a} + {1'b0, (alu_ctrl[0] ? ~alu_b : alu_b)} + {{N{1'b0}}, alu_ctrl[0]};
  assign alu_carry = alu_sum[N];
  assign alu_result = (alu_ctrl == 2'b10) ? (alu_a & alu_b) :
                      (alu_ctrl == 2'b11) ? (alu_a | alu_b) : alu_sum[N-1:0];

  alu_arbiter #(.N(N)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req0_a     (req0_a),
    .i_req0_b     (req0_b),
    .i_req0_ctrl  (req0_ctrl),
    .i_req1_a     (req1_a),
    .i_req1_b     (req1_b),
    .i_req1_ctrl  (req1_ctrl),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_ctrl   (alu_ctrl),
    .i_alu_result (alu_result),
    .i_alu_carry  (alu_carry),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_carry  (rsp_carry)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] v, input logic [N-1:0] r, input logic c);
    check({tag, "_valid"},  32'(rsp_valid),  32'(v));
    check({tag, "_result"}, 32'(rsp_result), 32'(r));
    check({tag, "_carry"},  32'(rsp_carry),  32'(c));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req0_a = 8'hF0; req0_b = 8'h20; req0_ctrl = 2'b00;
    req1_a = 8'h0F; req1_b = 8'hF0; req1_ctrl = 2'b11;

    // Reset held two cycles with both requesters valid.
    tick();
    check("rst_req_ready_c1", 32'(req_ready), 32'h0);
    tick();
    check("rst_req_ready_c2", 32'(req_ready), 32'h0);
    check_rsp("rst", 2'b00, 8'h00, 1'b0);

    // First contended grant after reset goes to port 0: add F0+20.
    reset = 1'b0;
    #1;
    check("add_grant", 32'(req_ready), 32'h1);
    check("add_alu_a", 32'(alu_a), 32'hF0);
    check("add_alu_b", 32'(alu_b), 32'h20);
    check("add_alu_ctrl", 32'(alu_ctrl), 32'h0);
    tick();
    check_rsp("add", 2'b01, 8'h10, 1'b1);

    // Idle cycle drains the response; ALU inputs read zero.
    req_valid = 2'b00;
    #1;
    check("idle_grant", 32'(req_ready), 32'h0);
    check("idle_alu_b", 32'(alu_b), 32'h0);
    tick();
    check("idle_rsp_valid", 32'(rsp_valid), 32'h0);

    // Backpressure: port1 and 3C&0F, then its consumer stalls 3 cycles.
    req1_a = 8'h3C; req1_b = 8'h0F; req1_ctrl = 2'b10;
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    #1;
    check("and_grant", 32'(req_ready), 32'h2);
    check("and_alu_ctrl", 32'(alu_ctrl), 32'h2);
    tick();
    check_rsp("and", 2'b10, 8'h0C, 1'b0);

    req0_a = 8'h05; req0_b = 8'h07; req0_ctrl = 2'b01;
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_grant", 32'(req_ready), 32'h0);
      check("stall_alu_a", 32'(alu_a), 32'h0);
      tick();
      check_rsp("stall", 2'b10, 8'h0C, 1'b0);
    end

    // Owner consumes; port0 (sub 5-7) is granted the same cycle.
    rsp_ready = 2'b10;
    #1;
    check("sub_grant", 32'(req_ready), 32'h1);
    check("sub_alu_a", 32'(alu_a), 32'h05);
    check("sub_alu_b", 32'(alu_b), 32'h07);
    tick();
    check_rsp("sub", 2'b01, 8'hFE, 1'b0);

    // Wrong-owner ready: only port1's ready is high while port0 owns the slot.
    req1_a = 8'h0F; req1_b = 8'hF0; req1_ctrl = 2'b11;
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    #1;
    check("wrong_owner_grant", 32'(req_ready), 32'h0);
    tick();
    check_rsp("wrong_owner", 2'b01, 8'hFE, 1'b0);

    rsp_ready = 2'b11;
    #1;
    check("or_grant", 32'(req_ready), 32'h2);
    tick();
    check_rsp("or", 2'b10, 8'hFF, 1'b0);

    // Round-robin: both valid, consumer ready; pointer now at port 0.
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_grant", 32'(req_ready), (i % 2 == 1) ? 32'h2 : 32'h1);
      tick();
      check_rsp("rr", (i % 2 == 1) ? 2'b10 : 2'b01, (i % 2 == 1) ? 8'hFF : 8'hFE, 1'b0);
    end

    // Reset while a response is held unconsumed (pointer is at port 1).
    rsp_ready = 2'b00;
    reset = 1'b1;
    #1;
    check("midrst_grant", 32'(req_ready), 32'h0);
    tick();
    check_rsp("midrst", 2'b00, 8'h00, 1'b0);

    reset = 1'b0;
    rsp_ready = 2'b11;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'h1);
    tick();
    check_rsp("post_rst", 2'b01, 8'hFE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
